counter_sequencer: RTL and testbench
====================================

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter: PRESC_W, 4, width of prescaler compare value and internal prescaler counter.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  pulse; loads configuration and (re)starts counting.
REQ-005 stop  input  1  pulse; aborts any activity, returns to IDLE.
REQ-006 pause  input  1  level; freezes counting while high in RUN.
REQ-007 dir  input  1  1 = count up, 0 = count down; sampled at start.
REQ-008 oneshot  input  1  1 = halt at terminal, 0 = wrap; sampled at start.
REQ-009 limit  input  3  terminal/reload bound; sampled at start.
REQ-010 presc  input  PRESC_W  count advances every presc+1 active cycles; sampled at start.
REQ-011 count  output  3  current count value, registered.
REQ-012 tc  output  1  one-cycle terminal-count pulse, registered.
REQ-013 busy  output  1  high in RUN or PAUSE, registered.
REQ-014 done  output  1  high while in DONE, registered.

Function
REQ-015 FSM states SHALL be IDLE, RUN, PAUSE, DONE; input priority stop > start > pause.
REQ-016 Start value SHALL be 0 when dir=1, limit when dir=0; terminal value SHALL be limit when dir=1, 0 when dir=0.
REQ-017 start in any state SHALL latch dir/oneshot/limit/presc, load count with start value, clear prescaler counter, enter RUN.
REQ-018 stop in RUN/PAUSE/DONE SHALL enter IDLE, clear count to 0, clear done; stop in IDLE has no effect.
REQ-019 In RUN with pause=0, prescaler counter SHALL increment each cycle; when equal to latched presc a tick occurs and it clears to 0.
REQ-020 On a tick with count != terminal, count SHALL step by +1 (up) or -1 (down).
REQ-021 On a tick with count == terminal and oneshot=0, count SHALL reload start value and tc SHALL be 1 the following cycle.
REQ-022 On a tick with count == terminal and oneshot=1, count SHALL hold, FSM SHALL enter DONE, tc SHALL be 1 the following cycle.
REQ-023 limit=0 SHALL keep count at 0 with tc asserted after every tick (wrap) or after the first tick (oneshot).
REQ-024 RUN with pause=1 SHALL enter PAUSE; PAUSE SHALL freeze count and prescaler counter; pause=0 SHALL return to RUN, resuming from the frozen prescaler value.
REQ-025 tc SHALL never be high for more than one consecutive cycle unless presc=0 and limit=0 in wrap mode.
REQ-026 Configuration input changes outside a start cycle SHALL NOT affect an ongoing sequence.
REQ-027 IDLE and DONE SHALL hold count unchanged; busy SHALL be 0 in both.

Reset
REQ-028 rstn=0 SHALL immediately force state IDLE, count=0, tc=0, busy=0, done=0, prescaler counter and latched configuration to 0, regardless of clk.
REQ-029 Reset asserted mid-sequence SHALL abort it; after release the block SHALL stay IDLE until start.

Verification
REQ-030 limit=5, dir=1, presc=0, oneshot=0, start at edge E0 -> count 0,1,2,3,4,5 after E0..E5, count=0 and tc=1 after E6 only, repeating every 6 cycles.
REQ-031 limit=3, dir=0, presc=2, oneshot=1, start -> count 3,2,1,0 each held 3 cycles, then done=1, busy=0, tc=1 for one cycle, count holds 0.
REQ-032 RUN at count=2 with prescaler mid-way, pause high 5 cycles -> busy=1, count and tick phase unchanged; after release, next tick at same remaining distance.
REQ-033 stop and start asserted same cycle in RUN -> IDLE, count=0, busy=0; start alone in DONE -> RUN with fresh start value.
REQ-034 rstn pulsed low mid-count (count=4) between clock edges -> count=0, busy=0, done=0 immediately; limit changes without start have no effect.

Source files
------------

// File: rtl/counter_sequencer_if.sv
// Control/status bundle for counter_sequencer: configuration and command
// inputs towards the sequencer, count and status flags back to the controller.
interface counter_sequencer_if #(
  parameter int unsigned PRESC_W = 4
);
  logic               start;
  logic               stop;
  logic               pause;
  logic               dir;
  logic               oneshot;
  logic [2:0]         limit;
  logic [PRESC_W-1:0] presc;
  logic [2:0]         count;
  logic               tc;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, pause, dir, oneshot, limit, presc,
    input  count, tc, busy, done
  );

  modport slave (
    input  start, stop, pause, dir, oneshot, limit, presc,
    output count, tc, busy, done
  );
endinterface

// File: rtl/counter_sequencer.sv
// Prescaled up/down 3-bit counter with wrap or one-shot termination,
// start/stop/pause control and registered status outputs.
module counter_sequencer #(
  parameter int unsigned PRESC_W = 4
) (
  input  logic              clk,
  input  logic              rstn,
  counter_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_e;

  state_e             state_q;
  logic               dir_q;
  logic               oneshot_q;
  logic [2:0]         limit_q;
  logic [PRESC_W-1:0] presc_q;
  logic [PRESC_W-1:0] pcnt_q;
  logic [2:0]         count_q;
  logic               tc_q;
  logic               busy_q;
  logic               done_q;

  logic [2:0]         load_val;
  logic [2:0]         reload_val;
  logic [2:0]         term_val;
  logic               at_term;
  logic               presc_hit;

  always_comb begin
    load_val   = bus.dir ? '0 : bus.limit;
    reload_val = dir_q ? '0 : limit_q;
    term_val   = dir_q ? limit_q : '0;
    at_term    = (count_q == term_val);
    presc_hit  = (pcnt_q == presc_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      dir_q     <= 1'b0;
      oneshot_q <= 1'b0;
      limit_q   <= '0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      count_q   <= '0;
      tc_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      tc_q <= 1'b0;
      // stop outranks start even in IDLE, where it is otherwise a no-op
      if (bus.stop) begin
        if (state_q != IDLE) begin
          state_q <= IDLE;
          count_q <= '0;
          pcnt_q  <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      end else if (bus.start) begin
        dir_q     <= bus.dir;
        oneshot_q <= bus.oneshot;
        limit_q   <= bus.limit;
        presc_q   <= bus.presc;
        count_q   <= load_val;
        pcnt_q    <= '0;
        state_q   <= RUN;
        busy_q    <= 1'b1;
        done_q    <= 1'b0;
      end else begin
        unique case (state_q)
          RUN: begin
            if (bus.pause) begin
              state_q <= PAUSE;
            end else if (presc_hit) begin
              pcnt_q <= '0;
              if (!at_term) begin
                count_q <= dir_q ? count_q + 3'd1 : count_q - 3'd1;
              end else if (!oneshot_q) begin
                count_q <= reload_val;
                tc_q    <= 1'b1;
              end else begin
                tc_q    <= 1'b1;
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              pcnt_q <= pcnt_q + 1'b1;
            end
          end
          // the release cycle only returns to RUN; counting resumes on the next one
          PAUSE: begin
            if (!bus.pause) begin
              state_q <= RUN;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_comb begin
    bus.count = count_q;
    bus.tc    = tc_q;
    bus.busy  = busy_q;
    bus.done  = done_q;
  end

  tc_single_pulse: assert property (
    @(posedge clk) disable iff (!rstn)
    tc_q |=> (!tc_q || (presc_q == '0 && limit_q == '0 && !oneshot_q))
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboard bench for counter_sequencer: an arithmetic model predicts the
// outputs after every edge, a negedge monitor compares them against the DUT.
module tb_counter_sequencer;
  localparam int unsigned PRESC_W = 4;

  typedef struct {
    int count;
    bit tc;
    bit busy;
    bit done;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   passes = 0;
  exp_t expq[$];

  // model: mode 0=idle 1=run 2=pause 3=done; n = active run cycles since start
  int m_mode = 0;
  int m_n    = 0;
  int m_cnt  = 0;
  int m_lim  = 0;
  int m_pr   = 0;
  bit m_dir  = 1'b0;
  bit m_os   = 1'b0;

  counter_sequencer_if #(.PRESC_W(PRESC_W)) bus ();

  counter_sequencer #(.PRESC_W(PRESC_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic model_edge();
    exp_t e;
    bit   tc = 1'b0;
    int   s, len, p;
    if (bus.stop) begin
      if (m_mode != 0) begin
        m_mode = 0;
        m_cnt  = 0;
      end
    end else if (bus.start) begin
      m_dir  = bus.dir;
      m_os   = bus.oneshot;
      m_lim  = int'(bus.limit);
      m_pr   = int'(bus.presc);
      m_n    = 0;
      m_mode = 1;
      m_cnt  = m_dir ? 0 : m_lim;
    end else if (m_mode == 1) begin
      if (bus.pause) begin
        m_mode = 2;
      end else begin
        m_n++;
        if (m_n % (m_pr + 1) == 0) begin
          s   = m_n / (m_pr + 1);
          len = m_lim + 1;
          if (m_os && s >= len) begin
            m_mode = 3;
            m_cnt  = m_dir ? m_lim : 0;
            tc     = 1'b1;
          end else begin
            p     = s % len;
            m_cnt = m_dir ? p : m_lim - p;
            tc    = (p == 0);
          end
        end
      end
    end else if (m_mode == 2 && !bus.pause) begin
      m_mode = 1;
    end
    e.count = m_cnt;
    e.tc    = tc;
    e.busy  = (m_mode == 1 || m_mode == 2);
    e.done  = (m_mode == 3);
    expq.push_back(e);
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      checks++;
      if (int'(bus.count) == e.count && bus.tc == e.tc && bus.busy == e.busy && bus.done == e.done)
        passes++;
      else
        $display("FAIL cycle_check t=%0t actual count=%0d tc=%0b busy=%0b done=%0b required count=%0d tc=%0b busy=%0b done=%0b",
                 $time, bus.count, bus.tc, bus.busy, bus.done, e.count, e.tc, e.busy, e.done);
    end
  end

  task automatic cyc(input bit st, input bit sp, input bit pa, input bit d,
                     input bit os, input int lim, input int pr);
    bus.start   = st;
    bus.stop    = sp;
    bus.pause   = pa;
    bus.dir     = d;
    bus.oneshot = os;
    bus.limit   = 3'(lim);
    bus.presc   = PRESC_W'(pr);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  // idle-command cycle with scrambled configuration, which must be ignored
  task automatic cyc_q(input bit pa);
    cyc(1'b0, 1'b0, pa, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
        int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
  endtask

  task automatic check_reset(input string name);
    checks++;
    if (bus.count == 3'd0 && bus.tc == 1'b0 && bus.busy == 1'b0 && bus.done == 1'b0)
      passes++;
    else
      $display("FAIL %s actual count=%0d tc=%0b busy=%0b done=%0b required all zero",
               name, bus.count, bus.tc, bus.busy, bus.done);
  endtask

  task automatic reset_pulse();
    rstn = 1'b0;
    #1;
    check_reset("async_reset");
    m_mode = 0; m_cnt = 0; m_n = 0; m_lim = 0; m_pr = 0; m_dir = 0; m_os = 0;
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    bit pa_r = 1'b0;
    rstn        = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.pause   = 1'b0;
    bus.dir     = 1'b0;
    bus.oneshot = 1'b0;
    bus.limit   = '0;
    bus.presc   = '0;
    #2;
    check_reset("power_on_reset");
    @(negedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) cyc_q(1'b0);

    // up count, wrap, limit 5, presc 0
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 5, 0);
    repeat (14) cyc_q(1'b0);

    // down count, oneshot, limit 3, presc 2, then idle in DONE
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3, 2);
    repeat (16) cyc_q(1'b0);

    // restart from DONE, then stop+start together in RUN
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4, 1);
    repeat (5) cyc_q(1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6, 0);
    repeat (3) cyc_q(1'b0);

    // pause mid-prescale at count 2
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7, 3);
    repeat (9) cyc_q(1'b0);
    repeat (5) cyc_q(1'b1);
    repeat (12) cyc_q(1'b0);

    // limit 0 corner cases
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
    repeat (4) cyc_q(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1);
    repeat (4) cyc_q(1'b0);

    // reset mid-count, then idle with config churn until restart
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 7, 0);
    repeat (4) cyc_q(1'b0);
    reset_pulse();
    repeat (6) cyc_q(1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1);
    repeat (8) cyc_q(1'b0);

    for (int i = 0; i < 2500; i++) begin
      bit st, sp;
      int pr;
      st = ($urandom_range(0, 39) == 0);
      sp = ($urandom_range(0, 69) == 0);
      if ($urandom_range(0, 7) == 0) pa_r = ~pa_r;
      pr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2));
      cyc(st, sp, pa_r, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 7)), pr);
      if ($urandom_range(0, 499) == 0) reset_pulse();
    end

    @(negedge clk);
    #1;
    checks++;
    if (expq.size() == 0)
      passes++;
    else
      $display("FAIL scoreboard_drain actual pending=%0d required 0", expq.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
